// File: rtl/adder_pg_stage_pkg.sv
// Shared definitions for the prefix-adder front end: data width, lane modes, lane LSB patterns.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
`ifndef LEN_DATA
`define LEN_DATA 31
`endif

package adder_pg_stage_pkg;

    localparam int DATA_W = `LEN_DATA + 1;

    // Lane-mode encodings; the fourth code is reserved and behaves like LANE_32.
    typedef enum logic [1:0] {
        LANE_32   = 2'd0,
        LANE_16   = 2'd1,
        LANE_8    = 2'd2,
        LANE_RSVD = 2'd3
    } lane_mode_e;

    localparam int LANE_W_32 = 32;
    localparam int LANE_W_16 = 16;
    localparam int LANE_W_8  = 8;

    // One bit set at the LSB of every lane of width w.
    function automatic logic [DATA_W-1:0] lane_lsb_vec(input int w);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W; i++) begin
            v[i] = ((i % w) == 0);
        end
        return v;
    endfunction

    localparam logic [DATA_W-1:0] LSB_32 = lane_lsb_vec(LANE_W_32);
    localparam logic [DATA_W-1:0] LSB_16 = lane_lsb_vec(LANE_W_16);
    localparam logic [DATA_W-1:0] LSB_8  = lane_lsb_vec(LANE_W_8);

    // Per-entry payload held in the output and skid registers (tag kept separately,
    // since its width is a module parameter).
    typedef struct packed {
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] cin;
    } pg_t;

endpackage

// File: rtl/adder_pg_stage_if.sv
// Handshake bundle between the operand source, the g/p front end and the first prefix stage.
// Latency: n/a (wires only).
// Backpressure: carries in_valid/in_ready on the input side and out_valid/out_ready on the output side.
interface adder_pg_stage_if
    import adder_pg_stage_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_sub;
    logic [1:0]        lane_mode;
    logic [TAG_W-1:0]  tag_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] generate_out;
    logic [DATA_W-1:0] propogate_out;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] cin_vec;
    logic [TAG_W-1:0]  tag_out;

    // Operand source / downstream consumer side.
    modport master (
        output in_valid, op_a, op_b, op_sub, lane_mode, tag_in, flush, out_ready,
        input  in_ready, out_valid, generate_out, propogate_out, mask, cin_vec, tag_out
    );

    // The g/p stage itself.
    modport slave (
        input  in_valid, op_a, op_b, op_sub, lane_mode, tag_in, flush, out_ready,
        output in_ready, out_valid, generate_out, propogate_out, mask, cin_vec, tag_out
    );
endinterface

// File: rtl/adder_lane_decode.sv
// Lane decode: turns lane_mode/op_sub into the prefix combine mask and per-lane carry-in vector.
// Latency: combinational.
// Backpressure: none.
module adder_lane_decode
    import adder_pg_stage_pkg::*;
(
    input  logic [1:0]        lane_mode,
    input  logic              op_sub,
    output logic [DATA_W-1:0] mask,
    output logic [DATA_W-1:0] cin_vec
);

    logic [DATA_W-1:0] lsb;

    // Pick the lane-LSB pattern, then derive combine-enable and carry-in from it.
    always_comb begin
        lsb = LSB_32;
        case (lane_mode_e'(lane_mode))
            LANE_16: lsb = LSB_16;
            LANE_8:  lsb = LSB_8;
            default: lsb = LSB_32;   // LANE_32 and the reserved code
        endcase
        // No combine across a lane boundary; bit 0 has no lower neighbour so it stays enabled.
        mask    = ~lsb;
        mask[0] = 1'b1;
        cin_vec = op_sub ? lsb : '0;
    end

endmodule

// File: rtl/adder_pg_stage.sv
// Operand prep: registers bitwise g/p, lane mask and carry-in vector for the first prefix stage.
// Latency: 1 cycle from input acceptance to registered output.
// Backpressure: output register plus one skid entry; in_ready is a flop, low only while the skid is full.
module adder_pg_stage
    import adder_pg_stage_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_pg_stage_if.slave   bus
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] dec_mask;
    logic [DATA_W-1:0] dec_cin;
    pg_t               new_dat;

    logic              enq;
    logic              deq;

    logic              or_vld_q, or_vld_d;
    logic              sk_vld_q, sk_vld_d;
    logic              in_rdy_q, in_rdy_d;
    pg_t               or_dat_q, or_dat_d;
    pg_t               sk_dat_q, sk_dat_d;
    logic [TAG_W-1:0]  or_tag_q, or_tag_d;
    logic [TAG_W-1:0]  sk_tag_q, sk_tag_d;

    adder_lane_decode u_lane_decode (
        .lane_mode (bus.lane_mode),
        .op_sub    (bus.op_sub),
        .mask      (dec_mask),
        .cin_vec   (dec_cin)
    );

    // Raw bitwise g/p of A and the (optionally inverted) B; carry-in is kept separate.
    always_comb begin
        b_eff        = bus.op_sub ? ~bus.op_b : bus.op_b;
        new_dat.g    = bus.op_a & b_eff;
        new_dat.p    = bus.op_a ^ b_eff;
        new_dat.mask = dec_mask;
        new_dat.cin  = dec_cin;
    end

    // Output register / skid register next state.
    always_comb begin
        enq      = bus.in_valid && in_rdy_q;
        deq      = or_vld_q && bus.out_ready;
        or_vld_d = or_vld_q;
        sk_vld_d = sk_vld_q;
        or_dat_d = or_dat_q;
        sk_dat_d = sk_dat_q;
        or_tag_d = or_tag_q;
        sk_tag_d = sk_tag_q;

        if (bus.flush) begin
            // Everything held, and anything arriving this cycle, is discarded.
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (deq) begin
            if (sk_vld_q) begin
                // in_ready is low whenever the skid is full, so no enqueue competes here.
                or_dat_d = sk_dat_q;
                or_tag_d = sk_tag_q;
                sk_vld_d = 1'b0;
            end else if (enq) begin
                or_dat_d = new_dat;
                or_tag_d = bus.tag_in;
            end else begin
                or_vld_d = 1'b0;
            end
        end else if (enq) begin
            if (!or_vld_q) begin
                or_vld_d = 1'b1;
                or_dat_d = new_dat;
                or_tag_d = bus.tag_in;
            end else begin
                sk_vld_d = 1'b1;
                sk_dat_d = new_dat;
                sk_tag_d = bus.tag_in;
            end
        end

        in_rdy_d = !sk_vld_d;
    end

    // State registers; reset clears both valid bits and zeroes the visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_vld_q <= 1'b0;
            sk_vld_q <= 1'b0;
            in_rdy_q <= 1'b1;
            or_dat_q <= '0;
            sk_dat_q <= '0;
            or_tag_q <= '0;
            sk_tag_q <= '0;
        end else begin
            or_vld_q <= or_vld_d;
            sk_vld_q <= sk_vld_d;
            in_rdy_q <= in_rdy_d;
            or_dat_q <= or_dat_d;
            sk_dat_q <= sk_dat_d;
            or_tag_q <= or_tag_d;
            sk_tag_q <= sk_tag_d;
        end
    end

    assign bus.in_ready      = in_rdy_q;
    assign bus.out_valid     = or_vld_q;
    assign bus.generate_out  = or_dat_q.g;
    assign bus.propogate_out = or_dat_q.p;
    assign bus.mask          = or_dat_q.mask;
    assign bus.cin_vec       = or_dat_q.cin;
    assign bus.tag_out       = or_tag_q;

endmodule

// File: tb/tb_adder_pg_stage.sv
// Self-checking bench for adder_pg_stage: directed literal cases plus randomized traffic vs a queue model.
// Latency: n/a.
// Backpressure: randomized out_ready, in_valid and occasional flush.
module tb_adder_pg_stage;
    import adder_pg_stage_pkg::*;

    localparam int TAG_W = 4;

    logic clk;
    logic rst_n;

    adder_pg_stage_if #(.TAG_W(TAG_W)) bus ();

    adder_pg_stage #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] c;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t q[$];
    bit   m_pop;
    bit   m_push;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the arithmetic definition of each field.
    function automatic exp_t model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic sub, input logic [1:0] mode,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [DATA_W-1:0] bb;
        int w;
        bb = sub ? ~b : b;
        e.g = a & bb;
        e.p = a ^ bb;
        w = (mode == 2'd1) ? 16 : (mode == 2'd2) ? 8 : 32;
        for (int i = 0; i < DATA_W; i++) begin
            e.m[i] = !((i > 0) && (i % w == 0));
            e.c[i] = (i % w == 0) ? sub : 1'b0;
        end
        e.tag = tag;
        return e;
    endfunction

    // Model: a FIFO of depth two; ready means fewer than two held entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (bus.flush) begin
            q.delete();
        end else begin
            m_pop  = (q.size() > 0) && bus.out_ready;
            m_push = bus.in_valid && (q.size() < 2);
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(model(bus.op_a, bus.op_b, bus.op_sub, bus.lane_mode, bus.tag_in));
        end
    end

    // Every cycle out of reset: flags always, payload whenever valid.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("g", 64'(bus.generate_out), 64'(q[0].g));
                chk("p", 64'(bus.propogate_out), 64'(q[0].p));
                chk("mask", 64'(bus.mask), 64'(q[0].m));
                chk("cin_vec", 64'(bus.cin_vec), 64'(q[0].c));
                chk("tag_out", 64'(bus.tag_out), 64'(q[0].tag));
            end
        end
    end

    task automatic set_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic sub, input logic [1:0] mode, input logic [TAG_W-1:0] tag);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_sub    = sub;
        bus.lane_mode = mode;
        bus.tag_in    = tag;
        bus.in_valid  = 1'b1;
    endtask

    // Offer one op for a single edge, then land on the following negedge.
    task automatic run_one(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic sub, input logic [1:0] mode, input logic [TAG_W-1:0] tag);
        set_op(a, b, sub, mode, tag);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.lane_mode = 2'd0;
        bus.tag_in    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst g", 64'(bus.generate_out), 64'd0);
        chk("rst p", 64'(bus.propogate_out), 64'd0);
        chk("rst mask", 64'(bus.mask), 64'd0);
        chk("rst cin", 64'(bus.cin_vec), 64'd0);
        chk("rst tag", 64'(bus.tag_out), 64'd0);

        // Literal cases.
        run_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 2'd0, 4'd1);
        chk("add valid", 64'(bus.out_valid), 64'd1);
        chk("add g", 64'(bus.generate_out), 64'h0000_0001);
        chk("add p", 64'(bus.propogate_out), 64'h0000_00FE);
        chk("add mask", 64'(bus.mask), 64'hFFFF_FFFF);
        chk("add cin", 64'(bus.cin_vec), 64'h0);
        run_one(32'd5, 32'd3, 1'b1, 2'd0, 4'd2);
        chk("sub g", 64'(bus.generate_out), 64'h0000_0004);
        chk("sub p", 64'(bus.propogate_out), 64'hFFFF_FFF9);
        chk("sub cin", 64'(bus.cin_vec), 64'h0000_0001);
        run_one(32'd5, 32'd3, 1'b1, 2'd2, 4'd3);
        chk("4x8 mask", 64'(bus.mask), 64'hFEFE_FEFF);
        chk("4x8 cin", 64'(bus.cin_vec), 64'h0101_0101);
        run_one(32'd5, 32'd3, 1'b1, 2'd1, 4'd4);
        chk("2x16 mask", 64'(bus.mask), 64'hFFFE_FFFF);
        chk("2x16 cin", 64'(bus.cin_vec), 64'h0001_0001);
        run_one(32'd5, 32'd3, 1'b1, 2'd3, 4'd5);
        chk("rsvd mask", 64'(bus.mask), 64'hFFFF_FFFF);
        chk("rsvd cin", 64'(bus.cin_vec), 64'h0000_0001);
        cyc();

        // Backpressure: three back-to-back offers against a stalled consumer.
        bus.out_ready = 1'b0;
        set_op(32'h11, 32'h22, 1'b0, 2'd0, 4'd1);
        cyc();
        bus.tag_in = 4'd2;
        cyc();
        bus.tag_in = 4'd3;
        @(negedge clk);
        chk("bp in_ready low", 64'(bus.in_ready), 64'd0);
        chk("bp head tag", 64'(bus.tag_out), 64'd1);
        cyc();
        @(negedge clk);
        chk("bp hold tag", 64'(bus.tag_out), 64'd1);
        chk("bp hold valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("bp drain 2", 64'(bus.tag_out), 64'd2);
        chk("bp drain 2 valid", 64'(bus.out_valid), 64'd1);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp drain 3", 64'(bus.tag_out), 64'd3);
        chk("bp drain 3 valid", 64'(bus.out_valid), 64'd1);
        cyc();
        @(negedge clk);
        chk("bp empty", 64'(bus.out_valid), 64'd0);

        // Flush with both entries held and an offer pending.
        bus.out_ready = 1'b0;
        set_op(32'h1, 32'h2, 1'b0, 2'd0, 4'd4);
        cyc();
        bus.tag_in = 4'd5;
        cyc();
        bus.tag_in = 4'd6;
        bus.flush  = 1'b1;
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("flush nothing out", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a held output.
        bus.out_ready = 1'b0;
        run_one(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 2'd2, 4'd7);
        chk("pre-rst valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid-rst g", 64'(bus.generate_out), 64'd0);
        chk("mid-rst p", 64'(bus.propogate_out), 64'd0);
        chk("mid-rst mask", 64'(bus.mask), 64'd0);
        chk("mid-rst cin", 64'(bus.cin_vec), 64'd0);
        chk("mid-rst tag", 64'(bus.tag_out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 2'd0, 4'd9);
        chk("post-rst latency", 64'(bus.out_valid), 64'd1);
        chk("post-rst tag", 64'(bus.tag_out), 64'd9);
        chk("post-rst g", 64'(bus.generate_out), 64'h1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 39) == 0);
            bus.op_a      = $urandom;
            bus.op_b      = $urandom;
            bus.op_sub    = $urandom_range(0, 1);
            bus.lane_mode = 2'($urandom_range(0, 3));
            bus.tag_in    = 4'($urandom_range(0, 15));
        end
        cyc();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        chk("final drained", 64'(bus.out_valid), 64'd0);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
